// File: rtl/maxpool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxpool_pkg                                                          |
// | Shared state encoding and width helpers for the max-pool sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package maxpool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Never returns zero so that degenerate dimensions still give legal vectors.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Token layout, MSB first: {valid, prow[PROW_W-1:0], pcol[PCOL_W-1:0]}.
  function automatic int tok_w(input int prow_w, input int pcol_w);
    return 1 + prow_w + pcol_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxpool_frame_ctrl_if                                                |
// | Pixel stream, line-buffer drive and pooled-result signals.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface maxpool_frame_ctrl_if #(
  parameter int DW     = 16,
  parameter int PROW_W = 4,
  parameter int PCOL_W = 4
);
  logic                 start;
  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 s_ready;
  logic                 lb_in_valid;
  logic signed [DW-1:0] lb_data_in;
  logic                 pool_valid;
  logic [PROW_W-1:0]    pool_row;
  logic [PCOL_W-1:0]    pool_col;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output start, s_valid, s_data,
    input  s_ready, lb_in_valid, lb_data_in, pool_valid, pool_row, pool_col,
           busy, frame_done
  );

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, lb_in_valid, lb_data_in, pool_valid, pool_row, pool_col,
           busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/maxpool_frame_ctrl_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_tag_delay                                                       |
// | LAT-deep token shift register with synchronous clear.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pool_tag_delay #(
  parameter int LAT   = 2,
  parameter int TOK_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TOK_W-1:0] tok_in,
  output logic [TOK_W-1:0] tok_out
);
  logic [TOK_W-1:0] stage_q [LAT];
  logic [TOK_W-1:0] stage_d [LAT];

  // Shifts unconditionally: stall cycles must age tokens like any other cycle.
  always_comb begin
    stage_d[0] = tok_in;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tok_out = stage_q[LAT-1];
endmodule
`default_nettype wire

// File: rtl/maxpool_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxpool_frame_ctrl                                                   |
// | Frame sequencer: feeds the line buffer, tags stride-2 windows.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module maxpool_frame_ctrl
  import maxpool_pkg::*;
#(
  parameter int dataColNum = 28,
  parameter int dataRowNum = 28,
  parameter int wordlength = 16,
  parameter int LAT        = 2
) (
  input  logic                 clk,
  input  logic                 irst_n,
  maxpool_frame_ctrl_if.slave  bus
);
  localparam int COL_W  = clog2_min1(dataColNum);
  localparam int ROW_W  = clog2_min1(dataRowNum);
  localparam int PCOL_W = clog2_min1(dataColNum / 2);
  localparam int PROW_W = clog2_min1(dataRowNum / 2);
  localparam int TOK_W  = tok_w(PROW_W, PCOL_W);
  localparam int DRN_W  = clog2_min1(LAT + 1);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [PROW_W-1:0]  prow_hold_q, prow_hold_d;
  logic [PCOL_W-1:0]  pcol_hold_q, pcol_hold_d;

  logic               accept;
  logic               last_col;
  logic               last_row;
  logic [TOK_W-1:0]   tok_in;
  logic [TOK_W-1:0]   tok_out;
  logic               tok_valid;
  logic [PROW_W-1:0]  tok_prow;
  logic [PCOL_W-1:0]  tok_pcol;

  assign accept   = bus.s_valid && (state_q == ST_LOAD);
  assign last_col = (col_q == COL_W'(dataColNum - 1));
  assign last_row = (row_q == ROW_W'(dataRowNum - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drn_d   = drn_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              drn_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drn_q == DRN_W'(LAT - 1)) begin
          drn_d   = '0;
          state_d = ST_DONE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the odd/odd pixel completes a 2x2 window; trailing odd lines never do.
  always_comb begin
    tok_in = '0;
    if (accept && row_q[0] && col_q[0]) begin
      tok_in = {1'b1, PROW_W'(row_q >> 1), PCOL_W'(col_q >> 1)};
    end
  end

  pool_tag_delay #(
    .LAT   (LAT),
    .TOK_W (TOK_W)
  ) u_delay (
    .clk     (clk),
    .rst     (irst_n),
    .tok_in  (tok_in),
    .tok_out (tok_out)
  );

  assign tok_valid = tok_out[TOK_W-1];
  assign tok_prow  = tok_out[TOK_W-2 -: PROW_W];
  assign tok_pcol  = tok_out[PCOL_W-1:0];

  always_comb begin
    prow_hold_d = prow_hold_q;
    pcol_hold_d = pcol_hold_q;
    if (tok_valid) begin
      prow_hold_d = tok_prow;
      pcol_hold_d = tok_pcol;
    end
  end

  always_ff @(posedge clk) begin
    if (irst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      drn_q       <= '0;
      prow_hold_q <= '0;
      pcol_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drn_q       <= drn_d;
      prow_hold_q <= prow_hold_d;
      pcol_hold_q <= pcol_hold_d;
    end
  end

  assign bus.s_ready     = (state_q == ST_LOAD);
  assign bus.lb_in_valid = accept;
  assign bus.lb_data_in  = bus.s_data;
  assign bus.pool_valid  = tok_valid;
  assign bus.pool_row    = prow_hold_d;
  assign bus.pool_col    = pcol_hold_d;
  assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign bus.frame_done  = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_maxpool_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_maxpool_frame_ctrl                                                |
// | Four sequencer instances of differing frame sizes, scoreboard check. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_maxpool_frame_ctrl;
  import maxpool_pkg::*;

  localparam int ND   = 4;
  localparam int LATV = 2;
  localparam int DW   = 16;
  localparam int RS [ND] = '{28, 4, 5, 4};
  localparam int CS [ND] = '{28, 4, 3, 6};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ND-1:0]    rst_v, start_v, s_valid_v;
  logic [ND*DW-1:0] s_data_flat;
  logic [ND-1:0]    s_ready_v, lbv_v, pv_v, busy_v, done_v;
  logic [ND*DW-1:0] lbd_flat;
  logic [ND*8-1:0]  prow_flat, pcol_flat;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int R  = RS[g];
    localparam int C  = CS[g];
    localparam int PW = clog2_min1(R / 2);
    localparam int CW = clog2_min1(C / 2);

    maxpool_frame_ctrl_if #(.DW(DW), .PROW_W(PW), .PCOL_W(CW)) bus ();

    assign bus.start   = start_v[g];
    assign bus.s_valid = s_valid_v[g];
    assign bus.s_data  = s_data_flat[g*DW +: DW];

    maxpool_frame_ctrl #(
      .dataColNum (C),
      .dataRowNum (R),
      .wordlength (DW),
      .LAT        (LATV)
    ) dut (
      .clk    (clk),
      .irst_n (rst_v[g]),
      .bus    (bus)
    );

    assign s_ready_v[g]          = bus.s_ready;
    assign lbv_v[g]              = bus.lb_in_valid;
    assign lbd_flat[g*DW +: DW]  = bus.lb_data_in;
    assign pv_v[g]               = bus.pool_valid;
    assign prow_flat[g*8 +: 8]   = 8'(bus.pool_row);
    assign pcol_flat[g*8 +: 8]   = 8'(bus.pool_col);
    assign busy_v[g]             = bus.busy;
    assign done_v[g]             = bus.frame_done;
  end

  typedef struct {
    int cyc;
    int r;
    int c;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    int d;
    int mode;       // 0: s_valid held high, 1: random s_valid
    int poke;       // pulse start during LOAD and DRAIN
    int pulses;
    int fr, fc, lr, lc;
    int first_off;  // first pulse cycle minus start cycle, -1 = not fixed
    int gap;        // frame_done cycle minus last pulse cycle
    int busy;       // -1 = not fixed
  } vec_t;
  vec_t tbl [6];

  int total = 0;
  int bad   = 0;
  int n_acc, pulses, busy_cnt, done_n, done_cyc, last_acc, lb_err;
  int first_cyc, first_r, first_c, last_r, last_c, last_pulse, start_cyc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs_word(input int d);
    return int'({s_ready_v[d], lbv_v[d], pv_v[d], busy_v[d], done_v[d],
                 prow_flat[d*8 +: 8], pcol_flat[d*8 +: 8]});
  endfunction

  task automatic observe(input int d);
    exp_t e;
    if (pv_v[d]) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_row", int'(prow_flat[d*8 +: 8]), e.r);
        check("pulse_col", int'(pcol_flat[d*8 +: 8]), e.c);
      end else begin
        check("spurious_pulse", int'(pv_v[d]), 0);
      end
      if (pulses == 0) begin
        first_cyc = cyc;
        first_r   = int'(prow_flat[d*8 +: 8]);
        first_c   = int'(pcol_flat[d*8 +: 8]);
      end
      last_r     = int'(prow_flat[d*8 +: 8]);
      last_c     = int'(pcol_flat[d*8 +: 8]);
      last_pulse = cyc;
      pulses++;
    end
    if (busy_v[d]) busy_cnt++;
    if (done_v[d]) begin
      done_n++;
      done_cyc = cyc;
    end
  endtask

  // Inputs for the current cycle are already driven; commit it and observe the next.
  task automatic advance(input int d);
    bit acc;
    int r, c;
    #1;
    acc = s_valid_v[d] && s_ready_v[d];
    if (lbv_v[d] !== acc) lb_err++;
    else if (acc && (lbd_flat[d*DW +: DW] !== s_data_flat[d*DW +: DW])) lb_err++;
    if (acc) begin
      r = n_acc / CS[d];
      c = n_acc % CS[d];
      if ((r % 2 == 1) && (c % 2 == 1)) sb.push_back('{cyc + LATV, r / 2, c / 2});
      n_acc++;
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    observe(d);
  endtask

  task automatic run_frame(input vec_t v);
    int d, g;
    d = v.d;
    n_acc = 0; pulses = 0; busy_cnt = 0; done_n = 0; lb_err = 0;
    first_cyc = -1; first_r = -1; first_c = -1; last_r = -1; last_c = -1;
    sb.delete();
    start_cyc = cyc;
    check("idle_not_ready", int'(s_ready_v[d]), 0);
    start_v[d]   = 1'b1;
    s_valid_v[d] = 1'b0;
    advance(d);
    start_v[d] = 1'b0;
    check("ready_after_start", int'(s_ready_v[d]), 1);
    g = 0;
    while (n_acc < RS[d] * CS[d] && g < 20000) begin
      s_valid_v[d] = (v.mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_flat[d*DW +: DW] = DW'(n_acc + 1);
      start_v[d] = (v.poke != 0) && (n_acc == 5);
      advance(d);
      g++;
    end
    s_valid_v[d] = 1'b0;
    check("frame_accepts", n_acc, RS[d] * CS[d]);
    start_v[d] = (v.poke != 0);
    g = 0;
    while (done_n == 0 && g < 60) begin
      advance(d);
      start_v[d] = 1'b0;
      g++;
    end
    start_v[d] = 1'b0;
    check("frame_done_seen", done_n, 1);
    advance(d);
    check("frame_done_one_cycle", int'(done_v[d]), 0);
    check("pulse_count", pulses, v.pulses);
    check("first_row", first_r, v.fr);
    check("first_col", first_c, v.fc);
    check("last_row", last_r, v.lr);
    check("last_col", last_c, v.lc);
    if (v.first_off >= 0) check("first_pulse_offset", first_cyc - start_cyc, v.first_off);
    check("done_after_last_pulse", done_cyc - last_pulse, v.gap);
    check("done_after_last_accept", done_cyc - last_acc, LATV + 1);
    check("busy_span", busy_cnt, last_acc - start_cyc + LATV);
    if (v.busy >= 0) check("busy_cycles", busy_cnt, v.busy);
    check("scoreboard_empty", sb.size(), 0);
    check("lb_errors", lb_err, 0);
  endtask

  initial begin
    int g;
    tbl[0] = '{0, 0, 0, 196, 0, 0, 13, 13, 32, 1, 786};
    tbl[1] = '{0, 0, 0, 196, 0, 0, 13, 13, 32, 1, 786};
    tbl[2] = '{1, 1, 0,   4, 0, 0,  1,  1, -1, 1,  -1};
    tbl[3] = '{2, 0, 1,   2, 0, 0,  1,  0,  7, 5,  17};
    tbl[4] = '{1, 1, 1,   4, 0, 0,  1,  1, -1, 1,  -1};
    tbl[5] = '{3, 0, 0,   6, 0, 0,  1,  2, 10, 1,  26};

    rst_v = '1; start_v = '0; s_valid_v = '0; s_data_flat = '0;
    n_acc = 0; pulses = 0; busy_cnt = 0; done_n = 0; lb_err = 0;
    repeat (2) @(posedge clk);
    #1;
    start_v = '1;
    for (int d = 0; d < ND; d++) check("reset_outputs", outs_word(d), 0);
    @(posedge clk);
    #1;
    start_v = '0;
    rst_v   = '0;
    for (int d = 0; d < ND; d++) check("reset_beats_start", outs_word(d), 0);
    @(posedge clk);
    #1;

    // Abort mid-frame on the 4x6 instance with the 10th pixel's window token in flight.
    n_acc = 0; pulses = 0; sb.delete();
    start_v[3] = 1'b1;
    advance(3);
    start_v[3]   = 1'b0;
    s_valid_v[3] = 1'b1;
    g = 0;
    while (n_acc < 10 && g < 100) begin
      s_data_flat[3*DW +: DW] = DW'(n_acc + 1);
      advance(3);
      g++;
    end
    check("abort_accepts", n_acc, 10);
    check("abort_pre_pulses", pulses, 1);
    rst_v[3]     = 1'b1;
    s_valid_v[3] = 1'b0;
    sb.delete();
    advance(3);
    rst_v[3] = 1'b0;
    check("abort_outputs", outs_word(3), 0);
    repeat (6) advance(3);
    check("abort_no_pulse", pulses, 1);
    check("abort_idle", int'(s_ready_v[3]) + int'(busy_v[3]), 0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
`default_nettype wire
